// File: rtl/jk_pkg.sv
// Shared types and JK truth-table constants for the JK register/counter bank.
package jk_pkg;

    typedef enum logic {JK_BANK, COUNTER} jk_mode_t;

    // {J,K} encodings
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic n;
        n = q;
        case ({j, k})
            JK_HOLD: n = q;
            JK_CLR:  n = 1'b0;
            JK_SET:  n = 1'b1;
            JK_TOG:  n = ~q;
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jk_edge_det.sv
// Detects the qualifying edge of the emulated netlist clock in the MasterClock domain.
module jk_edge_det #(
    parameter bit FALL_EDGE = 1'b0
) (
    input  logic MasterClock,
    input  logic ResetL,
    input  logic CLK,
    output logic EDGE
);

    logic r_clk_d;
    logic w_rise;
    logic w_fall;

    // Loading CLK during reset means a level held across release is not seen as an edge.
    always_ff @(posedge MasterClock) begin
        r_clk_d <= CLK;
    end

    assign w_rise = CLK & ~r_clk_d;
    assign w_fall = ~CLK & r_clk_d;
    assign EDGE   = ResetL & (FALL_EDGE ? w_fall : w_rise);

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK flip-flops, either independent cells or a JK toggle-chain up-counter.
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int       WIDTH     = 4,
    parameter jk_mode_t MODE      = JK_BANK,
    parameter bit       FALL_EDGE = 1'b0
) (
    input  logic             MasterClock,
    input  logic             ResetL,
    input  logic             CLK,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             R,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             CE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    output logic             CO,
    output logic             EDGE
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_nxt;
    logic             w_edge;

    jk_edge_det #(.FALL_EDGE(FALL_EDGE)) u_edge (
        .MasterClock (MasterClock),
        .ResetL      (ResetL),
        .CLK         (CLK),
        .EDGE        (w_edge)
    );

    generate
        if (MODE == JK_BANK) begin : g_bank
            logic w_unused_bank;
            assign w_unused_bank = CE;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign w_nxt[i] = jk_next(J[i], K[i], r_q[i]);
            end
            assign CO = &r_q;
        end else begin : g_cnt
            logic [WIDTH:0] w_carry;
            logic           w_unused_cnt;
            assign w_unused_cnt = ^{J, K};
            // Prefix-AND toggle chain: bit i toggles when CE and all lower bits are 1.
            assign w_carry[0] = CE;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign w_nxt[i]     = r_q[i] ^ w_carry[i];
                assign w_carry[i+1] = w_carry[i] & r_q[i];
            end
            assign CO = w_carry[WIDTH];
        end
    endgenerate

    always_ff @(posedge MasterClock) begin
        if (!ResetL) begin
            r_q <= '0;
        end else if (w_edge) begin
            if (R)       r_q <= '0;
            else if (LD) r_q <= D;
            else         r_q <= w_nxt;
        end
    end

    assign Q    = r_q;
    assign QB   = ~r_q;
    assign EDGE = w_edge;

endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed bench: JK bank (rising), counter (rising) and counter (falling) instances.
module tb_jk_counter_bank;
    import jk_pkg::*;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic       clk_a, clk_b, clk_c;
    logic [3:0] j, k, d;
    logic       r, ld, ce;

    logic [3:0] q_a, qb_a, q_b, qb_b, q_c, qb_c;
    logic       co_a, co_b, co_c, edge_a, edge_b, edge_c;

    int tests = 0;
    int fails = 0;
    int edge_c_cnt = 0;

    always #5 mclk = ~mclk;

    jk_counter_bank #(.WIDTH(4), .MODE(JK_BANK), .FALL_EDGE(1'b0)) u_a (
        .MasterClock(mclk), .ResetL(rst_n), .CLK(clk_a), .J(j), .K(k), .R(r), .LD(ld),
        .D(d), .CE(ce), .Q(q_a), .QB(qb_a), .CO(co_a), .EDGE(edge_a));

    jk_counter_bank #(.WIDTH(4), .MODE(COUNTER), .FALL_EDGE(1'b0)) u_b (
        .MasterClock(mclk), .ResetL(rst_n), .CLK(clk_b), .J(j), .K(k), .R(r), .LD(ld),
        .D(d), .CE(ce), .Q(q_b), .QB(qb_b), .CO(co_b), .EDGE(edge_b));

    jk_counter_bank #(.WIDTH(4), .MODE(COUNTER), .FALL_EDGE(1'b1)) u_c (
        .MasterClock(mclk), .ResetL(rst_n), .CLK(clk_c), .J(j), .K(k), .R(r), .LD(ld),
        .D(d), .CE(ce), .Q(q_c), .QB(qb_c), .CO(co_c), .EDGE(edge_c));

    always @(negedge mclk) if (edge_c) edge_c_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Rising-edge pulse on instance a (0) or b (1); EDGE checked in the edge cycle.
    task automatic pulse(input int which);
        if (which == 0) clk_a = 1'b1; else clk_b = 1'b1;
        #1;
        chk(which == 0 ? "edge_a" : "edge_b", 32'(which == 0 ? edge_a : edge_b), 32'd1);
        tick();
        if (which == 0) clk_a = 1'b0; else clk_b = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; clk_a = 1'b1; clk_b = 1'b1; clk_c = 1'b0;
        j = '0; k = '0; d = '0; r = 1'b0; ld = 1'b0; ce = 1'b0;
        #1;
        repeat (3) tick();
        chk("rst_q_a",  32'(q_a),  32'h0);
        chk("rst_qb_a", 32'(qb_a), 32'hF);
        chk("rst_edge", 32'(edge_a), 32'h0);
        chk("rst_co_a", 32'(co_a), 32'h0);
        chk("rst_co_b", 32'(co_b), 32'h0);

        // Release while CLK high: no edge, no change
        rst_n = 1'b1;
        #1;
        chk("rel_edge_a", 32'(edge_a), 32'h0);
        tick();
        chk("rel_q_a", 32'(q_a), 32'h0);
        clk_a = 1'b0; clk_b = 1'b0;
        tick();
        chk("rel_q_a2", 32'(q_a), 32'h0);

        // JK bank
        j = 4'b0101; k = 4'b0011;
        pulse(0);
        chk("jk1_q", 32'(q_a), 32'h5);
        j = 4'b0011; k = 4'b0011;
        pulse(0);
        chk("jk2_q",  32'(q_a),  32'h6);
        chk("jk2_qb", 32'(qb_a), 32'h9);
        chk("jk2_co", 32'(co_a), 32'h0);
        j = 4'b1111; k = 4'b0000;
        repeat (2) tick();
        chk("jk_hold", 32'(q_a), 32'h6);
        pulse(0);
        chk("jk_set_q",  32'(q_a),  32'hF);
        chk("jk_set_co", 32'(co_a), 32'h1);
        j = '0;

        // Counter wrap
        ld = 1'b1; d = 4'hE;
        pulse(1);
        chk("ld_q", 32'(q_b), 32'hE);
        ld = 1'b0; ce = 1'b1;
        #1;
        chk("co_e", 32'(co_b), 32'h0);
        pulse(1);
        chk("wrap_f_q",  32'(q_b),  32'hF);
        chk("wrap_f_co", 32'(co_b), 32'h1);
        ce = 1'b0;
        #1;
        chk("co_ce0", 32'(co_b), 32'h0);
        ce = 1'b1;
        pulse(1);
        chk("wrap_0_q",  32'(q_b),  32'h0);
        chk("wrap_0_co", 32'(co_b), 32'h0);
        chk("wrap_0_qb", 32'(qb_b), 32'hF);
        pulse(1);
        chk("inc_q", 32'(q_b), 32'h1);
        ce = 1'b0;
        pulse(1);
        pulse(1);
        chk("ce0_hold", 32'(q_b), 32'h1);

        // Priority R > LD > count
        r = 1'b1; ld = 1'b1; d = 4'h9; ce = 1'b1;
        pulse(1);
        chk("prio_r", 32'(q_b), 32'h0);
        r = 1'b0;
        pulse(1);
        chk("prio_ld", 32'(q_b), 32'h9);

        // Reset in the edge cycle discards the increment
        d = 4'h7;
        pulse(1);
        chk("ld7", 32'(q_b), 32'h7);
        ld = 1'b0; ce = 1'b1;
        clk_b = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst_edge_b", 32'(edge_b), 32'h0);
        tick();
        chk("rst_mid_q", 32'(q_b), 32'h0);
        rst_n = 1'b1;
        tick();
        clk_b = 1'b0;
        tick();
        chk("rst_mid_q2", 32'(q_b), 32'h0);

        // Falling-edge counter: 3 full CLK periods
        edge_c_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            clk_c = 1'b1;
            #1;
            chk("fe_rise_edge", 32'(edge_c), 32'h0);
            tick();
            chk("fe_rise_q", 32'(q_c), 32'(i - 1));
            clk_c = 1'b0;
            #1;
            chk("fe_fall_edge", 32'(edge_c), 32'h1);
            chk("fe_fall_q", 32'(q_c), 32'(i - 1));
            tick();
            chk("fe_q", 32'(q_c), 32'(i));
        end
        tick();
        chk("fe_final_q", 32'(q_c), 32'h3);
        chk("fe_edge_cnt", 32'(edge_c_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
